// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and PC helpers for the fetch stage.
// Used by fetch_unit and ifid_register. Optional halt feature: FETCH_HALT_EN.
package fetch_pkg;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam int unsigned PC_STEP_DEFAULT  = 2;
    localparam logic [15:0] HALT_WORD        = 16'h0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    // Instructions are halfword aligned; bit 0 of any PC is dropped.
    function automatic logic [15:0] align_pc(input logic [15:0] a);
        return {a[15:1], 1'b0};
    endfunction

    // Sequential successor, wrapping modulo 2^16.
    function automatic logic [15:0] step_pc(
        input logic [15:0] a,
        input int unsigned s
    );
        logic [15:0] s16;
        s16 = s[15:0];
        return align_pc(a + s16);
    endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: valid bit plus instruction, pc and pc+step.
// Ports: clk, rst_n, flush (clear valid), load (capture fetch_*), id_* outputs.
module ifid_register
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic [15:0] fetch_instr,
    input  logic [15:0] fetch_pc,
    input  logic [15:0] fetch_pc_plus2,
    output logic        id_valid,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_plus2
);

    // Flush beats load; with neither asserted the stage holds (stall).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus2 <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid    <= 1'b1;
            id_instr    <= fetch_instr;
            id_pc       <= fetch_pc;
            id_pc_plus2 <= fetch_pc_plus2;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC select, redirect and optional halt.
// Ports: clk, rst_n, pc/instruction (imem), redirect_*, id_* handshake, halted.
// Build macro FETCH_HALT_EN enables halting on HALT_WORD.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc,
    input  logic [15:0] instruction,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_plus2,
    output logic        halted
);

    logic [15:0] pc_seq;
    logic        run;
    logic        load;
    logic        halt_hit;
    logic        take;

    assign pc_seq = step_pc(pc, PC_STEP);

`ifdef FETCH_HALT_EN
    fetch_state_t state;

    assign run      = (state == ST_RUN);
    assign halt_hit = load && (instruction == HALT_WORD);

    // Redirect is the only way out of HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            halted <= 1'b0;
        end else if (redirect_valid) begin
            state  <= ST_RUN;
            halted <= 1'b0;
        end else if (halt_hit) begin
            state  <= ST_HALT;
            halted <= 1'b1;
        end
    end
`else
    assign run      = 1'b1;
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // Load when the ID slot is empty or being drained this edge.
    assign load = run && !redirect_valid && (!id_valid || id_ready);
    assign take = load && !halt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= align_pc(RESET_PC);
        end else if (redirect_valid) begin
            pc <= align_pc(redirect_pc);
        end else if (take) begin
            pc <= pc_seq;
        end
    end

    ifid_register u_ifid (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (redirect_valid || halt_hit),
        .load           (take),
        .fetch_instr    (instruction),
        .fetch_pc       (pc),
        .fetch_pc_plus2 (pc_seq),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus2    (id_pc_plus2)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// stimulus against a cycle-level reference model of the fetch rules.
module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus2;
    logic        halted;

    logic [15:0] mem [0:32767];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [15:0] m_pc, m_instr, m_idpc, m_plus;
    logic        m_valid, m_halted, m_run;

    fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus2    (id_pc_plus2),
        .halted         (halted)
    );

    assign instruction = mem[pc[15:1]];

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc     = RST_PC;
        m_valid  = 1'b0;
        m_instr  = '0;
        m_idpc   = '0;
        m_plus   = '0;
        m_halted = 1'b0;
        m_run    = 1'b1;
    endtask

    task automatic model_edge(input logic rv, input logic [15:0] rpc,
                              input logic rdy);
        logic [15:0] w;
        w = mem[m_pc[15:1]];
        if (rv) begin
            m_pc     = {rpc[15:1], 1'b0};
            m_valid  = 1'b0;
            m_halted = 1'b0;
            m_run    = 1'b1;
        end else if (m_run && (!m_valid || rdy)) begin
            if (HALT_EN && w == 16'h0000) begin
                m_run    = 1'b0;
                m_valid  = 1'b0;
                m_halted = 1'b1;
            end else begin
                m_instr = w;
                m_idpc  = m_pc;
                m_plus  = m_pc + 16'd2;
                m_valid = 1'b1;
                m_pc    = m_pc + 16'd2;
            end
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 ns later.
    task automatic tick(input logic rv, input logic [15:0] rpc,
                        input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(posedge clk);
        model_edge(rv, rpc, rdy);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({pc, id_valid, id_instr, id_pc, id_pc_plus2, halted} !==
            {RST_PC, 1'b0, 48'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h v=%b i=%h ipc=%h p2=%h h=%b want pc=%h rest 0",
                     pc, id_valid, id_instr, id_pc, id_pc_plus2, halted, RST_PC);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({pc, id_valid} !== {RST_PC, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_held: pc=%h v=%b want %h 0", pc, id_valid, RST_PC);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        tick(1'b0, 16'h0, 1'b1);
        n_checks++;
        if ({id_valid, id_pc, id_instr, id_pc_plus2, pc} !==
            {1'b1, 16'h0000, 16'h8180, 16'h0002, 16'h0002}) begin
            n_fail++;
            $display("FAIL seq_first: v=%b ipc=%h i=%h p2=%h pc=%h want 1 0000 8180 0002 0002",
                     id_valid, id_pc, id_instr, id_pc_plus2, pc);
        end
        tick(1'b0, 16'h0, 1'b1);
        n_checks++;
        if ({id_valid, id_pc, id_instr, id_pc_plus2, pc} !==
            {1'b1, 16'h0002, 16'h2CB2, 16'h0004, 16'h0004}) begin
            n_fail++;
            $display("FAIL seq_second: v=%b ipc=%h i=%h p2=%h pc=%h want 1 0002 2cb2 0004 0004",
                     id_valid, id_pc, id_instr, id_pc_plus2, pc);
        end
    endtask

    task automatic test_stall();
        logic [15:0] w;
        w = mem[2];
        tick(1'b0, 16'h0, 1'b1);
        n_checks++;
        if ({id_valid, id_pc, pc} !== {1'b1, 16'h0004, 16'h0006}) begin
            n_fail++;
            $display("FAIL stall_pre: v=%b ipc=%h pc=%h want 1 0004 0006",
                     id_valid, id_pc, pc);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 16'h0, 1'b0);
            n_checks++;
            if ({id_valid, id_pc, id_instr, pc} !== {1'b1, 16'h0004, w, 16'h0006}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: v=%b ipc=%h i=%h pc=%h want 1 0004 %h 0006",
                         k, id_valid, id_pc, id_instr, pc, w);
            end
        end
        tick(1'b0, 16'h0, 1'b1);
        n_checks++;
        if ({id_valid, id_pc, pc} !== {1'b1, 16'h0006, 16'h0008}) begin
            n_fail++;
            $display("FAIL stall_release: v=%b ipc=%h pc=%h want 1 0006 0008",
                     id_valid, id_pc, pc);
        end
    endtask

    task automatic test_redirect_stall();
        tick(1'b0, 16'h0, 1'b0);
        tick(1'b1, 16'h0003, 1'b0);
        n_checks++;
        if ({id_valid, pc} !== {1'b0, 16'h0002}) begin
            n_fail++;
            $display("FAIL redir_flush: v=%b pc=%h want 0 0002", id_valid, pc);
        end
        tick(1'b0, 16'h0, 1'b1);
        n_checks++;
        if ({id_valid, id_pc, pc} !== {1'b1, 16'h0002, 16'h0004}) begin
            n_fail++;
            $display("FAIL redir_load: v=%b ipc=%h pc=%h want 1 0002 0004",
                     id_valid, id_pc, pc);
        end
    endtask

    task automatic test_wrap();
        tick(1'b1, 16'hFFFE, 1'b1);
        n_checks++;
        if ({id_valid, pc} !== {1'b0, 16'hFFFE}) begin
            n_fail++;
            $display("FAIL wrap_redir: v=%b pc=%h want 0 fffe", id_valid, pc);
        end
        tick(1'b0, 16'h0, 1'b1);
        n_checks++;
        if ({id_valid, id_pc, id_pc_plus2, pc} !==
            {1'b1, 16'hFFFE, 16'h0000, 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap_top: v=%b ipc=%h p2=%h pc=%h want 1 fffe 0000 0000",
                     id_valid, id_pc, id_pc_plus2, pc);
        end
        tick(1'b0, 16'h0, 1'b1);
        n_checks++;
        if ({id_valid, id_pc, pc} !== {1'b1, 16'h0000, 16'h0002}) begin
            n_fail++;
            $display("FAIL wrap_next: v=%b ipc=%h pc=%h want 1 0000 0002",
                     id_valid, id_pc, pc);
        end
    endtask

    task automatic test_zero_word();
        logic [15:0] saved;
        saved = mem[6];
        mem[6] = 16'h0000;
        tick(1'b1, 16'h0008, 1'b1);
        tick(1'b0, 16'h0, 1'b1);
        tick(1'b0, 16'h0, 1'b1);
        tick(1'b0, 16'h0, 1'b1);
`ifdef FETCH_HALT_EN
        for (int k = 0; k < 11; k++) begin
            n_checks++;
            if ({halted, id_valid, pc} !== {1'b1, 1'b0, 16'h000C}) begin
                n_fail++;
                $display("FAIL halt_hold%0d: h=%b v=%b pc=%h want 1 0 000c",
                         k, halted, id_valid, pc);
            end
            if (k < 10) tick(1'b0, 16'h0, 1'b1);
        end
        tick(1'b1, 16'h0002, 1'b1);
        n_checks++;
        if ({halted, id_valid, pc} !== {1'b0, 1'b0, 16'h0002}) begin
            n_fail++;
            $display("FAIL halt_exit: h=%b v=%b pc=%h want 0 0 0002",
                     halted, id_valid, pc);
        end
        tick(1'b0, 16'h0, 1'b1);
        n_checks++;
        if ({halted, id_valid, id_pc} !== {1'b0, 1'b1, 16'h0002}) begin
            n_fail++;
            $display("FAIL halt_resume: h=%b v=%b ipc=%h want 0 1 0002",
                     halted, id_valid, id_pc);
        end
`else
        n_checks++;
        if ({halted, id_valid, id_instr, id_pc, pc} !==
            {1'b0, 1'b1, 16'h0000, 16'h000C, 16'h000E}) begin
            n_fail++;
            $display("FAIL zero_word: h=%b v=%b i=%h ipc=%h pc=%h want 0 1 0000 000c 000e",
                     halted, id_valid, id_instr, id_pc, pc);
        end
`endif
        mem[6] = saved;
    endtask

    task automatic test_async_reset();
        tick(1'b1, 16'h0006, 1'b1);
        tick(1'b0, 16'h0, 1'b1);
        tick(1'b0, 16'h0, 1'b0);
        n_checks++;
        if ({id_valid, id_pc, pc} !== {1'b1, 16'h0006, 16'h0008}) begin
            n_fail++;
            $display("FAIL areset_setup: v=%b ipc=%h pc=%h want 1 0006 0008",
                     id_valid, id_pc, pc);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({pc, id_valid, id_instr, id_pc, id_pc_plus2, halted} !==
            {RST_PC, 1'b0, 48'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL areset_async: pc=%h v=%b i=%h ipc=%h p2=%h h=%b want pc=%h rest 0",
                     pc, id_valid, id_instr, id_pc, id_pc_plus2, halted, RST_PC);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 16'h0, 1'b0);
        n_checks++;
        if ({id_valid, id_pc, pc} !== {1'b1, RST_PC, RST_PC + 16'd2}) begin
            n_fail++;
            $display("FAIL areset_first_load: v=%b ipc=%h pc=%h want 1 %h %h",
                     id_valid, id_pc, pc, RST_PC, RST_PC + 16'd2);
        end
    endtask

    task automatic test_random();
        logic        rv;
        logic        rdy;
        logic [15:0] rpc;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 400; k++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = 16'($urandom);
            tick(rv, rpc, rdy);
            n_checks++;
            if ({pc, id_valid, halted} !== {m_pc, m_valid, m_halted} ||
                (m_valid && {id_instr, id_pc, id_pc_plus2} !==
                            {m_instr, m_idpc, m_plus})) begin
                n_fail++;
                $display("FAIL random%0d: pc=%h v=%b h=%b i=%h ipc=%h p2=%h want pc=%h v=%b h=%b i=%h ipc=%h p2=%h",
                         k, pc, id_valid, halted, id_instr, id_pc, id_pc_plus2,
                         m_pc, m_valid, m_halted, m_instr, m_idpc, m_plus);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) begin
            logic [15:0] v;
            v = 16'($urandom);
            mem[a] = (v == 16'h0000) ? 16'h1234 : v;
        end
        mem[0] = 16'h8180;
        mem[1] = 16'h2CB2;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_zero_word();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 2: byte increment per sequential fetch (16-bit instructions).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port pc  output  16: current fetch address, driven to the instruction memory.
REQ-006 SHALL have port instruction  input  16: combinational instruction memory read data for pc.
REQ-007 SHALL have port redirect_valid  input  1: branch/jump taken this cycle.
REQ-008 SHALL have port redirect_pc  input  16: target address, valid when redirect_valid=1.
REQ-009 SHALL have port id_ready  input  1: decode stage can accept an instruction this cycle.
REQ-010 SHALL have port id_valid  output  1: id_instr, id_pc and id_pc_plus2 hold a valid instruction.
REQ-011 SHALL have port id_instr  output  16: fetched instruction.
REQ-012 SHALL have port id_pc  output  16: address id_instr was fetched from.
REQ-013 SHALL have port id_pc_plus2  output  16: id_pc + PC_STEP, modulo 2^16.
REQ-014 SHALL have port halted  output  1: fetch stopped on a halt word (FETCH_HALT_EN only; tied 0 otherwise).

Function
REQ-015 SHALL perform a transfer on a rising edge with id_valid=1 and id_ready=1.
REQ-016 SHALL "load" on a rising edge when (id_valid=0 or id_ready=1), no redirect, and state RUN: id_instr<=instruction, id_pc<=pc, id_pc_plus2<=pc+PC_STEP, id_valid<=1, pc<=pc+PC_STEP.
REQ-017 SHALL hold pc and all id_* outputs unchanged while id_valid=1 and id_ready=0 (stall); pc SHALL NOT advance during a stall.
REQ-018 SHALL on redirect_valid=1 set pc<={redirect_pc[15:1],1'b0} and id_valid<=0 at that edge, regardless of id_ready or stall (redirect wins).
REQ-019 SHALL force bit 0 of every PC value to 0 (misaligned targets truncated).
REQ-020 SHALL wrap pc from 16'hFFFE to 16'h0000 with no flag; id_pc_plus2 wraps likewise.
REQ-021 SHALL have states RUN and HALT; RUN->HALT only per REQ-028; HALT->RUN only on redirect_valid=1; reset->RUN.
REQ-022 SHALL give one-cycle latency: instruction at address A appears on id_instr the edge after pc=A with load enabled.
REQ-023 SHALL sustain one instruction per cycle when id_ready stays 1.
REQ-024 SHALL ensure the first id_valid=1 after reset release carries id_pc=RESET_PC.

Reset
REQ-025 SHALL while rst_n=0 asynchronously force pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_plus2=0, halted=0, state RUN.
REQ-026 SHALL discard any in-flight stall or pending redirect on reset assertion mid-operation; no partial update after deassertion.
REQ-027 SHALL perform its first load on the first rising edge with rst_n=1.

Configuration
REQ-028 SHALL with FETCH_HALT_EN defined: a load seeing instruction=16'h0000 enters HALT, sets id_valid<=0, holds pc at that address, sets halted=1; halted clears on the redirect edge.
REQ-029 SHALL without FETCH_HALT_EN: 16'h0000 is an ordinary instruction, the HALT state is absent, and halted is constant 0.

Structure
REQ-030 SHALL place RESET_PC default, PC_STEP, HALT_WORD (16'h0000) and the RUN/HALT state encoding in shared package fetch_pkg.
REQ-031 SHALL implement the id_* register stage (valid, hold, flush) as sub-module ifid_register; fetch_unit keeps pc, next-PC select and state.

Verification
REQ-032 SHALL cover: reset release, id_ready=1, memory words 0x8180,0x2CB2 at 0,2 -> id_pc 0,2 on consecutive edges, id_instr 0x8180 then 0x2CB2.
REQ-033 SHALL cover: id_ready=0 for 3 cycles with id_pc=4 -> pc stays 6, id_instr/id_pc stable, resumes id_pc=6 on release.
REQ-034 SHALL cover: redirect_valid=1, redirect_pc=16'h0003 during a stall -> next edge id_valid=0, pc=16'h0002; following edge id_pc=2.
REQ-035 SHALL cover: redirect to 16'hFFFE, id_ready=1 -> id_pc=FFFE, id_pc_plus2=0000, next id_pc=0000.
REQ-036 SHALL cover (FETCH_HALT_EN): word 0x0000 at address 12 -> halted=1, id_valid=0, pc=12 stable for 10 cycles; redirect to 2 -> halted=0, id_pc=2.
REQ-037 SHALL cover: rst_n pulsed low mid-stall at pc=8 -> pc=RESET_PC, id_valid=0 immediately without a clock edge.
